// File: rtl/revers_pkg.sv
// ----------------------------------------------------------------------------
// revers_pkg
// Shared definitions for the digit-reversal scheduler slice.
//   state_t      : controller states (IDLE -> RUN -> DONE -> IDLE)
//   *_DEF        : default widths for a 20-bit operand
//   clog2_min1() : index width helper that never returns 0
// ----------------------------------------------------------------------------
package revers_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DW_DEF   = 20;
  localparam int RW_DEF   = 24;
  localparam int MAXD_DEF = 7;

  // A single requester still needs a 1-bit id field, so clamp at 1.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/revers_sched_div10.sv
// ----------------------------------------------------------------------------
// div10_step
// Combinational divide-by-ten used for one digit step of the reversal.
//   n : DW-bit unsigned dividend
//   q : n / 10
//   r : n % 10 (0..9)
// ----------------------------------------------------------------------------
module div10_step #(
  parameter int DW = 20
) (
  input  logic [DW-1:0] n,
  output logic [DW-1:0] q,
  output logic [3:0]    r
);

  localparam int S  = DW + 4;
  localparam int PW = DW + S;
  localparam logic [S-1:0]    RECIP = S'((64'd1 << S) / 64'd10);
  localparam logic [DW+3:0]   TEN   = (DW+4)'(10);

  logic [PW-1:0]   prod;
  logic [DW-1:0]   q_est;
  logic [DW+3:0]   q_est_x10;
  logic [DW+3:0]   rem;

  // The truncated reciprocal 2^S/10 underestimates the quotient by at most
  // one for every DW-bit dividend, so a single remainder check corrects it.
  always_comb begin
    prod      = PW'(n) * PW'(RECIP);
    q_est     = prod[PW-1:S];
    q_est_x10 = ({4'b0000, q_est} << 3) + ({4'b0000, q_est} << 1);
    rem       = {4'b0000, n} - q_est_x10;
    if (rem >= TEN) begin
      q = q_est + 1'b1;
      r = 4'(rem - TEN);
    end else begin
      q = q_est;
      r = rem[3:0];
    end
  end

endmodule

// File: rtl/revers_sched.sv
// ----------------------------------------------------------------------------
// revers_sched
// One sequential decimal digit-reversal engine shared round-robin among NREQ
// requesters. Each job counts the decimal digits of its operand and returns
// the digit-reversed value (leading zeros of the result dropped).
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   req_valid    : per-requester job request
//   req_data     : per-requester operand, requester i at [i*DW +: DW]
//   req_ready    : one-hot accept strobe, only in IDLE
//   rsp_valid    : result available (DONE state)
//   rsp_ready    : consumer accepts result
//   rsp_id       : requester that owns the result
//   rsp_data     : digit-reversed value
//   rsp_ndig     : number of decimal digits, 1..MAXD
//   rsp_ovf      : result does not fit in DW bits
//   busy         : engine is in RUN or DONE
// ----------------------------------------------------------------------------
module revers_sched
  import revers_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = DW_DEF,
  parameter int RW   = RW_DEF,
  parameter int MAXD = MAXD_DEF,
  localparam int IDW = clog2_min1(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [RW-1:0]     rsp_data,
  output logic [3:0]        rsp_ndig,
  output logic              rsp_ovf,
  output logic              busy
);

  state_t          state;
  logic [DW-1:0]   n;
  logic [RW-1:0]   acc;
  logic [3:0]      cnt;
  logic [IDW-1:0]  id;
  logic [IDW-1:0]  rr_ptr;
  logic            ovf;

  logic            found;
  logic [IDW-1:0]  grant;
  logic [DW-1:0]   q;
  logic [3:0]      r;
  logic [RW-1:0]   acc_next;

  div10_step #(.DW(DW)) u_div10 (
    .n (n),
    .q (q),
    .r (r)
  );

  // Scan requesters starting at rr_ptr and wrapping; the first valid one wins.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  // Accept strobe is only offered while idle, and vanishes immediately when
  // reset is asserted so no requester believes it was served.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && !reset) req_ready[grant] = 1'b1;
  end

  // Append the lowest remaining digit to the reversed value; x10 as shift-add.
  always_comb begin
    acc_next = (acc << 3) + (acc << 1) + RW'(r);
  end

  // Controller: load on grant, peel one digit per RUN cycle, then hold the
  // result in DONE until the consumer takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      n      <= '0;
      acc    <= '0;
      cnt    <= '0;
      id     <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            n      <= req_data[int'(grant)*DW +: DW];
            acc    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            id     <= grant;
            rr_ptr <= (int'(grant) == NREQ-1) ? '0 : grant + 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          n   <= q;
          cnt <= cnt + 4'd1;
          if (q == '0) begin
            ovf   <= |acc_next[RW-1:DW];
            state <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_id    = id;
  assign rsp_data  = acc;
  assign rsp_ndig  = cnt;
  assign rsp_ovf   = ovf;

endmodule

// File: tb/tb_revers_sched.sv
// ----------------------------------------------------------------------------
// tb_revers_sched
// Self-checking bench for revers_sched: directed vector table, shift sequence,
// arbitration, backpressure, reset abort and random jobs against a
// string-based digit-reversal model.
// ----------------------------------------------------------------------------
module tb_revers_sched;

  localparam int NREQ = 2;
  localparam int DW   = 20;
  localparam int RW   = 24;
  localparam int MAXD = 7;
  localparam int IDW  = 1;

  logic               clock;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [RW-1:0]      rsp_data;
  logic [3:0]         rsp_ndig;
  logic               rsp_ovf;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int next_rr = 0;

  typedef struct {
    int          port;
    int unsigned data;
    int unsigned exp_rev;
    int          exp_ndig;
    int          exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  revers_sched #(.NREQ(NREQ), .DW(DW), .RW(RW), .MAXD(MAXD)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ndig  (rsp_ndig),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  // Free-running 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something stalls beyond every per-wait bound.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: write the number in decimal, read the characters backwards.
  function automatic void model(input int unsigned v, output int unsigned rev,
                                output int unsigned nd, output int unsigned ov);
    string s;
    s   = $sformatf("%0d", v);
    nd  = s.len();
    rev = 0;
    for (int i = s.len() - 1; i >= 0; i--) rev = rev * 10 + (int'(s[i]) - 48);
    ov  = (rev >= (32'd1 << DW)) ? 1 : 0;
  endfunction

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one job on a port, wait for its grant and result, consume it.
  task automatic apply_stimulus(input int port, input int unsigned data, output int lat,
                                output longint d, output longint nd, output longint ov,
                                output longint id);
    int waited;
    req_data[port*DW +: DW] = data[DW-1:0];
    req_valid[port] = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[port] && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    check_output("grant_seen", req_ready[port], 1);
    @(posedge clock); #1;
    req_valid[port] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    d  = rsp_data;
    nd = rsp_ndig;
    ov = rsp_ovf;
    id = rsp_id;
    next_rr = (port + 1) % NREQ;
    @(posedge clock); #1;
    check_output("rsp_released", rsp_valid, 0);
  endtask

  task automatic run_model_job(input string tag, input int port, input int unsigned data);
    int unsigned erev, end_, eov;
    int lat;
    longint d, nd, ov, id;
    model(data, erev, end_, eov);
    apply_stimulus(port, data, lat, d, nd, ov, id);
    check_output({tag, "_data"}, d, erev);
    check_output({tag, "_ndig"}, nd, end_);
    check_output({tag, "_ovf"}, ov, eov);
    check_output({tag, "_id"}, id, port);
    check_output({tag, "_lat"}, lat, end_ + 1);
  endtask

  initial begin
    int lat, waited, g, bad, stale;
    longint d, nd, ov, id;
    int unsigned erev, end_, eov, job_data;
    int unsigned arb_data[NREQ];

    vecs[0] = '{0, 12345,   54321,   5, 0, 6};
    vecs[1] = '{0, 0,       0,       1, 0, 2};
    vecs[2] = '{1, 120,     21,      3, 0, 4};
    vecs[3] = '{0, 100000,  1,       6, 0, 7};
    vecs[4] = '{1, 1048575, 5758401, 7, 1, 8};
    vecs[5] = '{0, 999999,  999999,  6, 0, 7};
    vecs[6] = '{1, 7,       7,       1, 0, 2};
    vecs[7] = '{1, 1000,    1,       4, 0, 5};

    // Reset state, with requests pending to prove the strobe is suppressed.
    reset = 1'b1; rsp_ready = 1'b1; req_data = '0; req_valid = 2'b11;
    repeat (2) @(posedge clock);
    #1;
    check_output("rst_req_ready", req_ready, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_data", rsp_data, 0);
    check_output("rst_rsp_ndig", rsp_ndig, 0);
    check_output("rst_rsp_ovf", rsp_ovf, 0);
    check_output("rst_rsp_id", rsp_id, 0);
    check_output("rst_busy", busy, 0);
    req_valid = '0;
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed vector table.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].port, vecs[i].data, lat, d, nd, ov, id);
      check_output($sformatf("vec%0d_data", i), d, vecs[i].exp_rev);
      check_output($sformatf("vec%0d_ndig", i), nd, vecs[i].exp_ndig);
      check_output($sformatf("vec%0d_ovf", i), ov, vecs[i].exp_ovf);
      check_output($sformatf("vec%0d_id", i), id, vecs[i].port);
      check_output($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
    end

    // Shifted sequence on port 0 against the model.
    for (int k = 0; k <= 13; k++) run_model_job($sformatf("shr%0d", k), 0, 32'd12345 >> k);

    // Arbitration: both ports request continuously.
    for (int p = 0; p < NREQ; p++) begin
      arb_data[p] = $urandom_range(0, (1 << DW) - 1);
      req_data[p*DW +: DW] = arb_data[p][DW-1:0];
    end
    req_valid = 2'b11;
    #1;
    for (int j = 0; j < 6; j++) begin
      waited = 0;
      while (req_ready == '0 && waited < 50) begin
        @(posedge clock); #1;
        waited++;
      end
      check_output("arb_onehot", $countones(req_ready), 1);
      g = req_ready[1] ? 1 : 0;
      check_output("arb_grant", g, next_rr);
      job_data = arb_data[g];
      @(posedge clock); #1;
      arb_data[g] = $urandom_range(0, (1 << DW) - 1);
      req_data[g*DW +: DW] = arb_data[g][DW-1:0];
      bad = 0; waited = 0;
      while (!rsp_valid && waited < 40) begin
        if (req_ready != '0) bad++;
        @(posedge clock); #1;
        waited++;
      end
      if (req_ready != '0) bad++;
      check_output("arb_no_grant_busy", bad, 0);
      model(job_data, erev, end_, eov);
      check_output("arb_rsp_id", rsp_id, g);
      check_output("arb_rsp_data", rsp_data, erev);
      next_rr = (g + 1) % NREQ;
      @(posedge clock); #1;
    end
    req_valid = '0;
    @(posedge clock); #1;
    while (busy) begin
      @(posedge clock); #1;
    end

    // Backpressure: result must hold and no grant may happen.
    rsp_ready = 1'b0;
    req_data[0 +: DW] = 20'd4321;
    req_valid[0] = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[0] && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < 40) begin
      @(posedge clock); #1;
      waited++;
    end
    check_output("bp_valid", rsp_valid, 1);
    req_data[DW +: DW] = 20'd77;
    req_valid[1] = 1'b1;
    bad = 0; stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      if (!rsp_valid || rsp_data != 24'd1234 || rsp_ndig != 4'd4 || rsp_id != 1'b0) stale++;
      if (req_ready != '0) bad++;
    end
    check_output("bp_hold", stale, 0);
    check_output("bp_no_grant", bad, 0);
    req_valid[1] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    check_output("bp_release_valid", rsp_valid, 0);
    check_output("bp_release_busy", busy, 0);
    next_rr = 1;

    // Reset during RUN aborts the job.
    req_data[0 +: DW] = 20'd99999;
    req_valid[0] = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[0] && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    @(posedge clock); #1;
    check_output("run_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_output("abort_rsp_valid", rsp_valid, 0);
    check_output("abort_rsp_data", rsp_data, 0);
    check_output("abort_rsp_ndig", rsp_ndig, 0);
    check_output("abort_busy", busy, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    next_rr = 0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (rsp_valid || busy) bad++;
    end
    check_output("abort_no_rsp", bad, 0);
    run_model_job("post_reset", 1, 123);

    // Random jobs against the model.
    for (int j = 0; j < 30; j++)
      run_model_job($sformatf("rnd%0d", j), $urandom_range(0, NREQ - 1),
                    $urandom_range(0, (1 << DW) - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
